// File: rtl/router_pkg.sv
// Shared types and helpers for the N-channel router control FSM.
package router_pkg;

    typedef enum logic [3:0] {
        DECODE       = 4'd0,
        LFD          = 4'd1,
        LOAD         = 4'd2,
        LOAD_PARITY  = 4'd3,
        CHECK_PARITY = 4'd4,
        FULL         = 4'd5,
        LAF          = 4'd6,
        WAIT_EMPTY   = 4'd7,
        DROP         = 4'd8
    } router_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for the WAIT_EMPTY state; flags expiry on the last allowed cycle.
module router_wait_timer
    import router_pkg::*;
#(
    parameter int WAIT_TMO = 64
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (clog2(WAIT_TMO) < 1) ? 1 : clog2(WAIT_TMO);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!resetn)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + CW'(1);
    end

    assign expired = enable && (cnt == CW'(WAIT_TMO - 1));

endmodule

// File: rtl/router_fsm_nch.sv
// 1-to-NUM_CH router controller: header decode, write steering, full/parity
// sequencing, invalid-address dropping and bounded wait-for-empty.
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 8,
    parameter int WAIT_TMO = 64
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic [NUM_CH-1:0] fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              busy,
    output logic              write_enb_reg,
    output logic [NUM_CH-1:0] dest_sel,
    output logic              drop_state,
    output logic              drop_evt
);

    router_state_e     state, nxt;
    logic [ADDR_W-1:0] addr_q, nxt_addr, hdr_addr;
    logic              hdr_valid, hdr_empty;
    logic              sel_full, sel_empty, sel_srst;
    logic              wait_clr, wait_en, wait_exp;

    assign hdr_addr  = data_in[ADDR_W-1:0];
    assign hdr_valid = 32'(hdr_addr) < NUM_CH;

    generate
        if (DATA_W > ADDR_W) begin : g_unused
            logic unused_hdr_bits;
            assign unused_hdr_bits = ^data_in[DATA_W-1:ADDR_W];
        end
    endgenerate

    function automatic logic [NUM_CH-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (a == ADDR_W'(i)) v[i] = 1'b1;
        return v;
    endfunction

    // Compare-based muxing keeps out-of-range addresses (DROP packets) harmless.
    always_comb begin
        sel_full  = 1'b0;
        sel_empty = 1'b0;
        sel_srst  = 1'b0;
        hdr_empty = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                sel_full  = fifo_full[i];
                sel_empty = fifo_empty[i];
                sel_srst  = soft_reset[i];
            end
            if (hdr_addr == ADDR_W'(i))
                hdr_empty = fifo_empty[i];
        end
    end

    always_comb begin
        nxt      = state;
        nxt_addr = addr_q;
        case (state)
            DECODE: if (pkt_valid) begin
                nxt_addr = hdr_addr;
                if (!hdr_valid)     nxt = DROP;
                else if (hdr_empty) nxt = LFD;
                else                nxt = WAIT_EMPTY;
            end
            LFD:          nxt = LOAD;
            LOAD:         if (sel_full) nxt = FULL;
                          else if (!pkt_valid) nxt = LOAD_PARITY;
            LOAD_PARITY:  nxt = CHECK_PARITY;
            CHECK_PARITY: nxt = sel_full ? FULL : DECODE;
            FULL:         if (!sel_full) nxt = LAF;
            LAF:          if (parity_done) nxt = DECODE;
                          else if (low_pkt_valid) nxt = LOAD_PARITY;
                          else nxt = LOAD;
            WAIT_EMPTY:   if (sel_empty) nxt = LFD;
                          else if (wait_exp) nxt = DROP;
            DROP:         if (!pkt_valid) nxt = DECODE;
            default:      nxt = DECODE;
        endcase
        // A channel's read-timeout aborts only the packet bound for that channel.
        if (sel_srst && state != DECODE && state != DROP)
            nxt = DECODE;
    end

    assign wait_clr = (nxt == WAIT_EMPTY) && (state != WAIT_EMPTY);
    assign wait_en  = (state == WAIT_EMPTY);

    router_wait_timer #(.WAIT_TMO(WAIT_TMO)) u_wait_timer (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (wait_clr),
        .enable  (wait_en),
        .expired (wait_exp)
    );

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= DECODE;
            addr_q        <= '0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            busy          <= 1'b0;
            write_enb_reg <= 1'b0;
            dest_sel      <= '0;
            drop_state    <= 1'b0;
            drop_evt      <= 1'b0;
        end else begin
            state         <= nxt;
            addr_q        <= nxt_addr;
            detect_add    <= (nxt == DECODE);
            lfd_state     <= (nxt == LFD);
            ld_state      <= (nxt == LOAD);
            laf_state     <= (nxt == LAF);
            full_state    <= (nxt == FULL);
            rst_int_reg   <= (nxt == CHECK_PARITY);
            busy          <= nxt inside {LFD, LOAD_PARITY, CHECK_PARITY, FULL, LAF, WAIT_EMPTY};
            write_enb_reg <= nxt inside {LOAD, LOAD_PARITY, LAF};
            dest_sel      <= (nxt == DECODE || nxt == DROP) ? '0 : onehot(nxt_addr);
            drop_state    <= (nxt == DROP);
            drop_evt      <= (nxt == DROP) && (state != DROP);
        end
    end

endmodule

// File: tb/tb_router_fsm_nch.sv
// Self-checking bench for router_fsm_nch: directed scenarios plus a randomized run against a behavioural model.
module tb_router_fsm_nch;

    localparam int NUM_CH   = 3;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 8;
    localparam int WAIT_TMO = 64;

    logic              clock = 1'b0;
    logic              resetn, pkt_valid, parity_done, low_pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic [NUM_CH-1:0] fifo_full, fifo_empty, soft_reset, dest_sel;
    logic              detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic              busy, write_enb_reg, drop_state, drop_evt;

    int checks = 0;
    int errors = 0;

    router_fsm_nch #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_TMO(WAIT_TMO)
    ) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .busy(busy), .write_enb_reg(write_enb_reg), .dest_sel(dest_sel),
        .drop_state(drop_state), .drop_evt(drop_evt)
    );

    always #5 clock = ~clock;

    function automatic logic [NUM_CH+8:0] obs();
        return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                busy, write_enb_reg, drop_state, dest_sel};
    endfunction

    // Expected output vector for a named phase of the packet flow.
    function automatic logic [NUM_CH+8:0] expv(input string s, input int a);
        logic [NUM_CH-1:0] ds;
        logic bz, we;
        ds = (s == "DEC" || s == "DROP") ? '0 : (NUM_CH'(1) << a);
        bz = (s == "LFD" || s == "LP" || s == "CHK" || s == "FULL" || s == "LAF" || s == "WAIT");
        we = (s == "LOAD" || s == "LP" || s == "LAF");
        return {s == "DEC", s == "LFD", s == "LOAD", s == "LAF", s == "FULL", s == "CHK",
                bz, we, s == "DROP", ds};
    endfunction

    task automatic idle();
        pkt_valid = 1'b0; data_in = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
        fifo_full = '0; fifo_empty = '1; soft_reset = '0;
    endtask

    task automatic step(input logic pv, input logic [DATA_W-1:0] d);
        pkt_valid = pv;
        data_in   = d;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        step(1'b0, '0);
        step(1'b0, '0);
        checks++;
        if (obs() !== expv("DEC", 0)) begin
            errors++; $display("FAIL reset_outputs got %h want %h", obs(), expv("DEC", 0));
        end
        checks++;
        if (drop_evt !== 1'b0) begin errors++; $display("FAIL reset_drop_evt got %b want 0", drop_evt); end
        resetn = 1'b1;
        step(1'b0, '0);
    endtask

    task automatic test_normal();
        string e[$] = '{"LFD", "LOAD", "LOAD", "LOAD", "LOAD", "LP", "CHK", "DEC"};
        int nwr = 0;
        idle();
        for (int i = 0; i < e.size(); i++) begin
            step(i < 5, (i == 0) ? 8'h02 : DATA_W'($urandom));
            nwr += int'(write_enb_reg);
            checks++;
            if (obs() !== expv(e[i], 2)) begin
                errors++; $display("FAIL normal_pkt step %0d got %h want %h (%s)", i, obs(), expv(e[i], 2), e[i]);
            end
        end
        checks++;
        if (nwr != 5) begin errors++; $display("FAIL normal_pkt write_cycles got %0d want 5", nwr); end
    endtask

    task automatic test_invalid();
        int nev = 0;
        idle();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0) ? 8'h03 : DATA_W'($urandom));
            nev += int'(drop_evt);
            checks++;
            if (obs() !== expv("DROP", 0)) begin
                errors++; $display("FAIL invalid_addr step %0d got %h want %h", i, obs(), expv("DROP", 0));
            end
            if (i == 0) begin
                checks++;
                if (drop_evt !== 1'b1) begin errors++; $display("FAIL invalid_addr drop_evt got %b want 1", drop_evt); end
            end
        end
        step(1'b0, '0);
        checks++;
        if (obs() !== expv("DEC", 0)) begin errors++; $display("FAIL invalid_addr return got %h want %h", obs(), expv("DEC", 0)); end
        checks++;
        if (nev != 1) begin errors++; $display("FAIL invalid_addr drop_evt_count got %0d want 1", nev); end
    endtask

    task automatic wait_phase(input string tag);
        idle();
        fifo_empty = 3'b101;
        step(1'b1, 8'h01);
        for (int i = 0; i < WAIT_TMO; i++) begin
            checks++;
            if (obs() !== expv("WAIT", 1)) begin
                errors++; $display("FAIL %s wait cycle %0d got %h want %h", tag, i, obs(), expv("WAIT", 1));
            end
            if (i < WAIT_TMO - 1) step(1'b1, DATA_W'($urandom));
        end
    endtask

    task automatic test_timeout();
        string e[$] = '{"LOAD", "LP", "CHK", "DEC"};
        wait_phase("timeout");
        step(1'b1, DATA_W'($urandom));
        checks++;
        if (obs() !== expv("DROP", 0) || drop_evt !== 1'b1) begin
            errors++; $display("FAIL timeout_drop got %h evt %b want %h evt 1", obs(), drop_evt, expv("DROP", 0));
        end
        step(1'b0, '0);
        checks++;
        if (obs() !== expv("DEC", 0)) begin errors++; $display("FAIL timeout_return got %h want %h", obs(), expv("DEC", 0)); end

        // Empty arriving on the expiry cycle must win.
        wait_phase("late_empty");
        fifo_empty = 3'b111;
        step(1'b1, DATA_W'($urandom));
        checks++;
        if (obs() !== expv("LFD", 1) || drop_evt !== 1'b0) begin
            errors++; $display("FAIL late_empty got %h evt %b want %h evt 0", obs(), drop_evt, expv("LFD", 1));
        end
        for (int i = 0; i < e.size(); i++) begin
            step(1'b0, '0);
            checks++;
            if (obs() !== expv(e[i], 1)) begin
                errors++; $display("FAIL late_empty tail %0d got %h want %h", i, obs(), expv(e[i], 1));
            end
        end
    endtask

    task automatic test_full();
        string e[$] = '{"LFD", "LOAD", "LOAD", "FULL", "FULL", "FULL", "LAF", "LP", "CHK", "DEC"};
        logic [2:0] f[$] = '{3'b000, 3'b000, 3'b110, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        idle();
        for (int i = 0; i < e.size(); i++) begin
            fifo_full     = f[i];
            low_pkt_valid = (i >= 6);
            step(i < 6, (i == 0) ? 8'h00 : DATA_W'($urandom));
            checks++;
            if (obs() !== expv(e[i], 0)) begin
                errors++; $display("FAIL full_path step %0d got %h want %h (%s)", i, obs(), expv(e[i], 0), e[i]);
            end
        end
    endtask

    task automatic test_soft_reset();
        string e[$] = '{"LFD", "LOAD", "LOAD", "LOAD", "DEC", "DEC"};
        logic [2:0] s[$] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000};
        idle();
        for (int i = 0; i < e.size(); i++) begin
            soft_reset = s[i];
            step(i < 5, (i == 0) ? 8'h02 : DATA_W'($urandom));
            checks++;
            if (obs() !== expv(e[i], 2)) begin
                errors++; $display("FAIL soft_reset step %0d got %h want %h (%s)", i, obs(), expv(e[i], 2), e[i]);
            end
        end
        idle();
        fifo_empty = 3'b101;
        step(1'b1, 8'h01);
        soft_reset = 3'b010;
        step(1'b1, DATA_W'($urandom));
        checks++;
        if (obs() !== expv("DEC", 0)) begin errors++; $display("FAIL soft_reset_wait got %h want %h", obs(), expv("DEC", 0)); end
        idle();
        step(1'b0, '0);
    endtask

    task automatic test_reset_in_full();
        idle();
        step(1'b1, 8'h01);
        step(1'b1, DATA_W'($urandom));
        fifo_full = 3'b010;
        step(1'b1, DATA_W'($urandom));
        checks++;
        if (obs() !== expv("FULL", 1)) begin errors++; $display("FAIL reset_in_full setup got %h want %h", obs(), expv("FULL", 1)); end
        resetn = 1'b0;
        step(1'b1, DATA_W'($urandom));
        checks++;
        if (obs() !== expv("DEC", 0) || drop_evt !== 1'b0) begin
            errors++; $display("FAIL reset_in_full got %h evt %b want %h evt 0", obs(), drop_evt, expv("DEC", 0));
        end
        resetn = 1'b1;
        idle();
        step(1'b0, '0);
    endtask

    task automatic test_random(input int ncyc);
        string ms = "DEC";
        string nx;
        int ma = 0;
        int mw = 0;
        logic pv, ev;
        logic [DATA_W-1:0] d;
        logic [NUM_CH-1:0] fl, em, sr;
        idle();
        resetn = 1'b0;
        step(1'b0, '0);
        resetn = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            pv = ($urandom_range(3) != 0);
            d  = DATA_W'($urandom);
            for (int k = 0; k < NUM_CH; k++) begin
                fl[k] = ($urandom_range(4) == 0);
                em[k] = ($urandom_range(9) < 6);
                sr[k] = ($urandom_range(40) == 0);
            end
            fifo_full = fl; fifo_empty = em; soft_reset = sr;
            parity_done = 1'($urandom); low_pkt_valid = 1'($urandom);

            nx = ms;
            if (ms == "DEC") begin
                if (pv) begin
                    ma = int'(d[ADDR_W-1:0]);
                    if (ma >= NUM_CH) nx = "DROP";
                    else if (em[ma]) nx = "LFD";
                    else begin nx = "WAIT"; mw = 0; end
                end
            end
            else if (ms == "LFD")  nx = "LOAD";
            else if (ms == "LOAD") nx = fl[ma] ? "FULL" : (!pv ? "LP" : "LOAD");
            else if (ms == "LP")   nx = "CHK";
            else if (ms == "CHK")  nx = fl[ma] ? "FULL" : "DEC";
            else if (ms == "FULL") nx = fl[ma] ? "FULL" : "LAF";
            else if (ms == "LAF")  nx = parity_done ? "DEC" : (low_pkt_valid ? "LP" : "LOAD");
            else if (ms == "WAIT") begin
                if (em[ma]) nx = "LFD";
                else if (mw >= WAIT_TMO - 1) nx = "DROP";
                mw++;
            end
            else if (ms == "DROP") nx = pv ? "DROP" : "DEC";
            if (ms != "DEC" && ms != "DROP" && ma < NUM_CH && sr[ma]) nx = "DEC";
            ev = (nx == "DROP") && (ms != "DROP");

            step(pv, d);
            checks++;
            if (obs() !== expv(nx, ma) || drop_evt !== ev) begin
                errors++;
                $display("FAIL random cyc %0d got %h evt %b want %h evt %b (%s->%s)",
                         c, obs(), drop_evt, expv(nx, ma), ev, ms, nx);
            end
            ms = nx;
        end
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        test_reset();
        test_normal();
        test_invalid();
        test_timeout();
        test_full();
        test_soft_reset();
        test_reset_in_full();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
